// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master drives the ID/EX side and hazard controls; slave is the execute stage itself.
interface ex_stage_if;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic        id_ex_alu_src;
  logic [4:0]  id_ex_alu_op;
  logic [4:0]  id_ex_shamt;
  logic [4:0]  id_ex_rd;
  logic        id_ex_wb;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic [1:0]  forwardA;
  logic [1:0]  forwardB;
  logic [31:0] mem_wb_result;
  logic        stall;
  logic        flush;

  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_wb;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic        ex_mem_overflow;
  logic        mul_busy;
  logic        ex_hold;

  modport master (
    output id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_alu_src,
           id_ex_alu_op, id_ex_shamt, id_ex_rd, id_ex_wb, id_ex_mem_read,
           id_ex_mem_write, forwardA, forwardB, mem_wb_result, stall, flush,
    input  ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_wb, ex_mem_mem_read, ex_mem_mem_write, ex_mem_overflow,
           mul_busy, ex_hold
  );

  modport slave (
    input  id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_alu_src,
           id_ex_alu_op, id_ex_shamt, id_ex_rd, id_ex_wb, id_ex_mem_read,
           id_ex_mem_write, forwardA, forwardB, mem_wb_result, stall, flush,
    output ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_wb, ex_mem_mem_read, ex_mem_mem_write, ex_mem_overflow,
           mul_busy, ex_hold
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding operand mux, ALU, iterative MULTU with HI/LO,
// and the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | no multiply in flight, HI/LO stable
// BUSY  | shift-add iterations running, mul_busy high
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input logic     clk,
  input logic     reset,
  ex_stage_if.slave bus
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDU = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBU = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_SLL  = 5'd10;
  localparam logic [4:0] OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA  = 5'd12;
  localparam logic [4:0] OP_LUI  = 5'd13;
  localparam logic [4:0] OP_MFHI = 5'd14;
  localparam logic [4:0] OP_MFLO = 5'd15;
  localparam logic [4:0] OP_MULTU = 5'd16;

  // Bits retired per BUSY cycle so that MUL_CYCLES steps always cover 32 bits.
  localparam int BPS = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam logic [5:0] CNT_LAST = 6'(MUL_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

  mul_state_t  state;
  logic [5:0]  cnt;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [63:0] acc_step;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_busy_q;

  logic        valid_q;
  logic [31:0] alu_result_q;
  logic [31:0] store_data_q;
  logic [4:0]  rd_q;
  logic        wb_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        overflow_q;

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        overflow;
  logic        is_hilo_op;
  logic        ex_hold;
  logic        mul_start;

  always_comb begin
    case (bus.forwardA)
      2'd1:    op_a = bus.mem_wb_result;
      2'd2:    op_a = alu_result_q;
      default: op_a = bus.id_ex_rs_data;
    endcase
    case (bus.forwardB)
      2'd1:    fwd_b = bus.mem_wb_result;
      2'd2:    fwd_b = alu_result_q;
      default: fwd_b = bus.id_ex_rt_data;
    endcase
    op_b = bus.id_ex_alu_src ? bus.id_ex_imm : fwd_b;
  end

  always_comb begin
    alu_result = 32'd0;
    overflow   = 1'b0;
    case (bus.id_ex_alu_op)
      OP_ADD: begin
        alu_result = op_a + op_b;
        overflow   = (op_a[31] == op_b[31]) && (alu_result[31] != op_a[31]);
      end
      OP_ADDU: alu_result = op_a + op_b;
      OP_SUB: begin
        alu_result = op_a - op_b;
        overflow   = (op_a[31] != op_b[31]) && (alu_result[31] != op_a[31]);
      end
      OP_SUBU: alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_result = {31'd0, op_a < op_b};
      OP_SLL:  alu_result = op_b << bus.id_ex_shamt;
      OP_SRL:  alu_result = op_b >> bus.id_ex_shamt;
      OP_SRA:  alu_result = 32'($signed(op_b) >>> bus.id_ex_shamt);
      OP_LUI:  alu_result = {op_b[15:0], 16'd0};
      OP_MFHI: alu_result = hi;
      OP_MFLO: alu_result = lo;
      default: alu_result = 32'd0;
    endcase
  end

  assign is_hilo_op = (bus.id_ex_alu_op == OP_MFHI) || (bus.id_ex_alu_op == OP_MFLO) ||
                      (bus.id_ex_alu_op == OP_MULTU);
  assign ex_hold    = mul_busy_q & bus.id_ex_valid & is_hilo_op;
  assign mul_start  = (state == IDLE) & bus.id_ex_valid & (bus.id_ex_alu_op == OP_MULTU) &
                      ~bus.stall & ~bus.flush & ~ex_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      rd_q         <= 5'd0;
      wb_q         <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (bus.stall) begin
      valid_q <= valid_q;
    end else if (bus.flush || ex_hold) begin
      valid_q      <= 1'b0;
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      rd_q         <= 5'd0;
      wb_q         <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q      <= bus.id_ex_valid;
      alu_result_q <= alu_result;
      store_data_q <= fwd_b;
      rd_q         <= bus.id_ex_valid ? bus.id_ex_rd : 5'd0;
      // A trapping add/sub and MULTU itself never write the register file.
      wb_q         <= bus.id_ex_valid & bus.id_ex_wb & ~overflow &
                      (bus.id_ex_alu_op != OP_MULTU);
      mem_read_q   <= bus.id_ex_valid & bus.id_ex_mem_read;
      mem_write_q  <= bus.id_ex_valid & bus.id_ex_mem_write;
      overflow_q   <= bus.id_ex_valid & overflow;
    end
  end

  always_comb begin
    acc_step = acc;
    for (int k = 0; k < BPS; k++) begin
      if (mplier[k]) acc_step = acc_step + (mcand << k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mul_busy_q <= 1'b0;
      cnt        <= 6'd0;
      mcand      <= 64'd0;
      mplier     <= 32'd0;
      acc        <= 64'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state      <= BUSY;
            mul_busy_q <= 1'b1;
            cnt        <= CNT_LAST;
            mcand      <= {32'd0, op_a};
            mplier     <= fwd_b;
            acc        <= 64'd0;
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << BPS;
          mplier <= mplier >> BPS;
          if (cnt == 6'd0) begin
            {hi, lo}   <= acc_step;
            state      <= IDLE;
            mul_busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ex_mem_valid      = valid_q;
  assign bus.ex_mem_alu_result = alu_result_q;
  assign bus.ex_mem_store_data = store_data_q;
  assign bus.ex_mem_rd         = rd_q;
  assign bus.ex_mem_wb         = wb_q;
  assign bus.ex_mem_mem_read   = mem_read_q;
  assign bus.ex_mem_mem_write  = mem_write_q;
  assign bus.ex_mem_overflow   = overflow_q;
  assign bus.mul_busy          = mul_busy_q;
  assign bus.ex_hold           = ex_hold;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, overflow, stall/flush priority,
// shifts/compares, MULTU timing with HI/LO readback, and reset mid-multiply.
module tb_ex_stage;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  ex_stage_if bus ();

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [1:0] fa, input logic [4:0] rd);
    bus.id_ex_valid   = 1'b1;
    bus.id_ex_alu_op  = op;
    bus.id_ex_rs_data = rs;
    bus.id_ex_rt_data = rt;
    bus.forwardA      = fa;
    bus.id_ex_rd      = rd;
    bus.id_ex_wb      = 1'b1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [1:0] fa, input logic [4:0] rd);
    drive(op, rs, rt, fa, rd);
    step();
  endtask

  // Returns the number of cycles mul_busy was seen high, bounded.
  task automatic wait_mul(output int busy_cycles, output int hold_low);
    busy_cycles = 0;
    hold_low    = 0;
    while (bus.mul_busy && busy_cycles < 200) begin
      if (!bus.ex_hold) hold_low++;
      busy_cycles++;
      step();
    end
  endtask

  int busy_n;
  int hold_lo;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.id_ex_valid     = 1'b0;
    bus.id_ex_rs_data   = '0;
    bus.id_ex_rt_data   = '0;
    bus.id_ex_imm       = '0;
    bus.id_ex_alu_src   = 1'b0;
    bus.id_ex_alu_op    = '0;
    bus.id_ex_shamt     = '0;
    bus.id_ex_rd        = '0;
    bus.id_ex_wb        = 1'b0;
    bus.id_ex_mem_read  = 1'b0;
    bus.id_ex_mem_write = 1'b0;
    bus.forwardA        = '0;
    bus.forwardB        = '0;
    bus.mem_wb_result   = '0;
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.ex_mem_valid), 32'd0);
    chk("rst_result", bus.ex_mem_alu_result, 32'd0);
    chk("rst_wb", 32'(bus.ex_mem_wb), 32'd0);
    chk("rst_busy", 32'(bus.mul_busy), 32'd0);
    reset = 1'b0;

    // forwarding: rs=5, mem_wb=7, ex_mem=9 for the select-2 case, rt=1
    bus.mem_wb_result = 32'd7;
    issue(5'd0, 32'd8, 32'd1, 2'd0, 5'd1);
    chk("fwd_setup9", bus.ex_mem_alu_result, 32'd9);
    issue(5'd0, 32'd5, 32'd1, 2'd2, 5'd1);
    chk("fwd_sel2", bus.ex_mem_alu_result, 32'd10);
    issue(5'd0, 32'd5, 32'd1, 2'd0, 5'd1);
    chk("fwd_sel0", bus.ex_mem_alu_result, 32'd6);
    issue(5'd0, 32'd5, 32'd1, 2'd1, 5'd1);
    chk("fwd_sel1", bus.ex_mem_alu_result, 32'd8);
    issue(5'd0, 32'd5, 32'd1, 2'd3, 5'd1);
    chk("fwd_sel3", bus.ex_mem_alu_result, 32'd6);
    chk("fwd_rd", 32'(bus.ex_mem_rd), 32'd1);

    // store data follows forwardB
    bus.forwardB = 2'd1;
    issue(5'd1, 32'd2, 32'd3, 2'd0, 5'd4);
    chk("store_fwdB", bus.ex_mem_store_data, 32'd7);
    chk("addu_fwdB", bus.ex_mem_alu_result, 32'd9);
    bus.forwardB = 2'd0;

    // signed overflow
    issue(5'd0, 32'h7FFF_FFFF, 32'd1, 2'd0, 5'd3);
    chk("add_ovf_res", bus.ex_mem_alu_result, 32'h8000_0000);
    chk("add_ovf_flag", 32'(bus.ex_mem_overflow), 32'd1);
    chk("add_ovf_wb", 32'(bus.ex_mem_wb), 32'd0);
    issue(5'd1, 32'h7FFF_FFFF, 32'd1, 2'd0, 5'd3);
    chk("addu_ovf_flag", 32'(bus.ex_mem_overflow), 32'd0);
    chk("addu_wb", 32'(bus.ex_mem_wb), 32'd1);
    issue(5'd2, 32'h8000_0000, 32'd1, 2'd0, 5'd3);
    chk("sub_ovf_flag", 32'(bus.ex_mem_overflow), 32'd1);

    // stall beats flush, then flush alone
    issue(5'd2, 32'd10, 32'd3, 2'd0, 5'd6);
    chk("sub_res", bus.ex_mem_alu_result, 32'd7);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    issue(5'd0, 32'd1, 32'd1, 2'd0, 5'd9);
    chk("stall_hold_res", bus.ex_mem_alu_result, 32'd7);
    chk("stall_hold_wb", 32'(bus.ex_mem_wb), 32'd1);
    chk("stall_hold_rd", 32'(bus.ex_mem_rd), 32'd6);
    bus.stall = 1'b0;
    issue(5'd0, 32'd1, 32'd1, 2'd0, 5'd9);
    chk("flush_valid", 32'(bus.ex_mem_valid), 32'd0);
    chk("flush_wb", 32'(bus.ex_mem_wb), 32'd0);
    chk("flush_rd", 32'(bus.ex_mem_rd), 32'd0);
    bus.flush = 1'b0;

    // shifts / compares / logic using the immediate path
    bus.id_ex_alu_src = 1'b1;
    bus.id_ex_imm     = 32'h8000_0000;
    bus.id_ex_shamt   = 5'd4;
    issue(5'd12, 32'd0, 32'd0, 2'd0, 5'd2);
    chk("sra", bus.ex_mem_alu_result, 32'hF800_0000);
    issue(5'd11, 32'd0, 32'd0, 2'd0, 5'd2);
    chk("srl", bus.ex_mem_alu_result, 32'h0800_0000);
    bus.id_ex_imm = 32'h0000_1234;
    issue(5'd13, 32'd0, 32'd0, 2'd0, 5'd2);
    chk("lui", bus.ex_mem_alu_result, 32'h1234_0000);
    bus.id_ex_alu_src = 1'b0;
    bus.id_ex_shamt   = 5'd0;
    issue(5'd8, 32'hFFFF_FFFF, 32'd1, 2'd0, 5'd2);
    chk("slt", bus.ex_mem_alu_result, 32'd1);
    issue(5'd9, 32'hFFFF_FFFF, 32'd1, 2'd0, 5'd2);
    chk("sltu", bus.ex_mem_alu_result, 32'd0);
    issue(5'd7, 32'h0F0F_0000, 32'h0000_00F0, 2'd0, 5'd2);
    chk("nor", bus.ex_mem_alu_result, 32'hF0F0_FF0F);
    issue(5'd20, 32'd5, 32'd5, 2'd0, 5'd2);
    chk("op_unused", bus.ex_mem_alu_result, 32'd0);

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF, then MFHI waits out BUSY
    issue(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 5'd8);
    chk("multu_valid", 32'(bus.ex_mem_valid), 32'd1);
    chk("multu_wb", 32'(bus.ex_mem_wb), 32'd0);
    chk("multu_busy", 32'(bus.mul_busy), 32'd1);
    drive(5'd14, 32'd0, 32'd0, 2'd0, 5'd10);
    #1;
    chk("mfhi_hold", 32'(bus.ex_hold), 32'd1);
    step();
    chk("mfhi_bubble", 32'(bus.ex_mem_valid), 32'd0);
    wait_mul(busy_n, hold_lo);
    chk("busy_cycles", 32'(busy_n + 1), 32'd32);
    chk("hold_during_busy", 32'(hold_lo), 32'd0);
    chk("hold_released", 32'(bus.ex_hold), 32'd0);
    step();
    chk("mfhi_res", bus.ex_mem_alu_result, 32'hFFFF_FFFE);
    chk("mfhi_valid", 32'(bus.ex_mem_valid), 32'd1);
    issue(5'd15, 32'd0, 32'd0, 2'd0, 5'd11);
    chk("mflo_res", bus.ex_mem_alu_result, 32'h0000_0001);

    // reset during BUSY cycle 10
    issue(5'd16, 32'd5, 32'd7, 2'd0, 5'd8);
    bus.id_ex_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("busy_before_rst", 32'(bus.mul_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(bus.mul_busy), 32'd0);
    issue(5'd14, 32'd0, 32'd0, 2'd0, 5'd10);
    chk("rst_hi", bus.ex_mem_alu_result, 32'd0);
    issue(5'd15, 32'd0, 32'd0, 2'd0, 5'd10);
    chk("rst_lo", bus.ex_mem_alu_result, 32'd0);

    issue(5'd16, 32'd3, 32'd4, 2'd0, 5'd8);
    bus.id_ex_valid = 1'b0;
    wait_mul(busy_n, hold_lo);
    chk("busy_cycles2", 32'(busy_n), 32'd32);
    issue(5'd15, 32'd0, 32'd0, 2'd0, 5'd10);
    chk("mul2_lo", bus.ex_mem_alu_result, 32'd12);
    issue(5'd14, 32'd0, 32'd0, 2'd0, 5'd10);
    chk("mul2_hi", bus.ex_mem_alu_result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
